// File: rtl/audio_pkg.sv
// Shared constants and types for the audio framing/serialising datapath.
package audio_pkg;
  localparam int SAMPLE_W  = 12;
  localparam int FRAME_LEN = 64;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_e;
endpackage

// File: rtl/frame_slot.sv
// One frame of sample storage: parallel load, parallel out, indexed read.
module frame_slot #(
  parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter int FRAME_LEN = audio_pkg::FRAME_LEN
) (
  input  logic                         clk,
  input  logic                         load,
  input  logic [SAMPLE_W-1:0]          din [0:FRAME_LEN-1],
  input  logic [$clog2(FRAME_LEN)-1:0] rd_idx,
  output logic [SAMPLE_W-1:0]          rd_data,
  output logic [SAMPLE_W-1:0]          dout [0:FRAME_LEN-1]
);
  logic [SAMPLE_W-1:0] mem [0:FRAME_LEN-1];

  always_ff @(posedge clk) begin
    if (load) mem <= din;
  end

  assign rd_data = mem[rd_idx];
  assign dout    = mem;
endmodule

// File: rtl/frame_serializer.sv
// Double-buffered frame-to-stream converter with valid/ready output.
module frame_serializer #(
  parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter int FRAME_LEN = audio_pkg::FRAME_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SAMPLE_W-1:0]          frame_in [0:FRAME_LEN-1],
  input  logic                         frame_valid,
  output logic                         frame_accept,
  output logic                         overrun,
  output logic [SAMPLE_W-1:0]          sample_out,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic [$clog2(FRAME_LEN)-1:0] sample_index,
  output logic                         sample_last,
  output logic                         busy
);
  import audio_pkg::*;

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  ser_state_e       state;
  logic             pend_valid;
  logic [IDX_W-1:0] idx;

  logic xfer, last_xfer;
  logic act_load, act_from_pend, pend_load, accept_d, drop_d;

  logic [SAMPLE_W-1:0] act_din        [0:FRAME_LEN-1];
  logic [SAMPLE_W-1:0] pend_dout      [0:FRAME_LEN-1];
  logic [SAMPLE_W-1:0] act_dout_unused[0:FRAME_LEN-1];
  logic [SAMPLE_W-1:0] act_rd;
  logic [SAMPLE_W-1:0] pend_rd_unused;

  // A last transfer frees one slot in the same cycle, so a frame arriving
  // then is accepted even with pending full.
  always_comb begin
    xfer          = (state == STREAM) && sample_ready;
    last_xfer     = xfer && (idx == LAST_IDX);
    act_load      = 1'b0;
    act_from_pend = 1'b0;
    pend_load     = 1'b0;
    accept_d      = 1'b0;
    drop_d        = 1'b0;
    if (frame_valid) begin
      if (state == IDLE) begin
        act_load = 1'b1;
        accept_d = 1'b1;
      end else if (!pend_valid) begin
        if (last_xfer) act_load  = 1'b1;
        else           pend_load = 1'b1;
        accept_d = 1'b1;
      end else if (last_xfer) begin
        pend_load = 1'b1;
        accept_d  = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
    if (last_xfer && pend_valid) begin
      act_load      = 1'b1;
      act_from_pend = 1'b1;
    end
    for (int unsigned i = 0; i < FRAME_LEN; i++)
      act_din[i] = act_from_pend ? pend_dout[i] : frame_in[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pend_valid   <= 1'b0;
      idx          <= '0;
      frame_accept <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_accept <= accept_d;
      overrun      <= drop_d;
      unique case (state)
        IDLE: begin
          idx <= '0;
          if (frame_valid) state <= STREAM;
        end
        STREAM: begin
          if (xfer) idx <= idx + 1'b1;
          if (last_xfer && !pend_valid && !frame_valid) state <= IDLE;
          if (pend_load)      pend_valid <= 1'b1;
          else if (last_xfer) pend_valid <= 1'b0;
        end
      endcase
    end
  end

  frame_slot #(.SAMPLE_W(SAMPLE_W), .FRAME_LEN(FRAME_LEN)) u_active (
    .clk    (clk),
    .load   (act_load),
    .din    (act_din),
    .rd_idx (idx),
    .rd_data(act_rd),
    .dout   (act_dout_unused)
  );

  frame_slot #(.SAMPLE_W(SAMPLE_W), .FRAME_LEN(FRAME_LEN)) u_pending (
    .clk    (clk),
    .load   (pend_load),
    .din    (frame_in),
    .rd_idx (idx),
    .rd_data(pend_rd_unused),
    .dout   (pend_dout)
  );

  assign sample_valid = (state == STREAM);
  assign sample_out   = sample_valid ? act_rd : '0;
  assign sample_index = idx;
  assign sample_last  = sample_valid && (idx == LAST_IDX);
  assign busy         = sample_valid || pend_valid;
endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: scripted table, hand sequences, random traffic vs a sample-queue model.
module tb_frame_serializer;
  import audio_pkg::*;

  localparam int SW = SAMPLE_W;
  localparam int FL = FRAME_LEN;
  localparam int IW = $clog2(FL);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_valid = 1'b0;
  logic          sample_ready = 1'b0;
  sample_t       frame_in [0:FL-1];
  logic          frame_accept, overrun, sample_valid, sample_last, busy;
  logic [SW-1:0] sample_out;
  logic [IW-1:0] sample_index;

  frame_serializer #(.SAMPLE_W(SW), .FRAME_LEN(FL)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_accept(frame_accept),
    .overrun     (overrun),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_index(sample_index),
    .sample_last (sample_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: every sample of every accepted frame not yet transferred, in order.
  sample_t q[$];
  bit      m_acc, m_ovr;
  sample_t cur_frame [0:FL-1];

  function automatic void check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  task automatic check_model();
    int sz = q.size();
    int e_idx = (FL - (sz % FL)) % FL;
    check("valid", int'(sample_valid), int'(sz > 0));
    check("busy", int'(busy), int'(sz > 0));
    check("accept", int'(frame_accept), int'(m_acc));
    check("overrun", int'(overrun), int'(m_ovr));
    if (sz > 0) begin
      check("data", int'(sample_out), int'(q[0]));
      check("index", int'(sample_index), e_idx);
      check("last", int'(sample_last), int'(e_idx == FL - 1));
    end
  endtask

  task automatic check_reset();
    check("rst_valid", int'(sample_valid), 0);
    check("rst_accept", int'(frame_accept), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_last", int'(sample_last), 0);
    check("rst_data", int'(sample_out), 0);
    check("rst_index", int'(sample_index), 0);
  endtask

  // Drives one cycle, advances the model across the edge, checks #1 after it.
  task automatic step(input bit fv, input bit rdy, input bit r);
    int held;
    frame_valid  = fv;
    sample_ready = rdy;
    rst          = r;
    frame_in     = cur_frame;
    if (r) begin
      q.delete();
      m_acc = 1'b0;
      m_ovr = 1'b0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      held  = (q.size() + FL - 1) / FL;
      m_acc = fv && (held < 2);
      m_ovr = fv && !m_acc;
      if (m_acc) for (int i = 0; i < FL; i++) q.push_back(cur_frame[i]);
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic make_frame(input int kind);
    for (int i = 0; i < FL; i++) begin
      case (kind)
        0:       cur_frame[i] = sample_t'(i);
        1:       cur_frame[i] = sample_t'(4095 - i);
        2:       cur_frame[i] = sample_t'(12'hA00 + i);
        default: cur_frame[i] = sample_t'($urandom);
      endcase
    end
  endtask

  typedef struct {
    int unsigned cyc;
    bit          fv;
    bit          is_chk;
    bit          e_valid;
    bit          e_accept;
    bit          e_overrun;
    bit          e_busy;
    bit          e_last;
    int unsigned e_idx;
    int unsigned e_data;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int pulse;
    bit fv;

    // Three frame pulses at 0, 5, 9 with ready high; the third finds both slots full.
    tbl.push_back('{0,   1, 0, 0, 0, 0, 0, 0, 0,  0});
    tbl.push_back('{5,   1, 0, 0, 0, 0, 0, 0, 0,  0});
    tbl.push_back('{9,   1, 0, 0, 0, 0, 0, 0, 0,  0});
    tbl.push_back('{1,   0, 1, 1, 1, 0, 1, 0, 0,  0});
    tbl.push_back('{2,   0, 1, 1, 0, 0, 1, 0, 1,  1});
    tbl.push_back('{6,   0, 1, 1, 1, 0, 1, 0, 5,  5});
    tbl.push_back('{10,  0, 1, 1, 0, 1, 1, 0, 9,  9});
    tbl.push_back('{11,  0, 1, 1, 0, 0, 1, 0, 10, 10});
    tbl.push_back('{64,  0, 1, 1, 0, 0, 1, 1, 63, 63});
    tbl.push_back('{65,  0, 1, 1, 0, 0, 1, 0, 0,  4095});
    tbl.push_back('{128, 0, 1, 1, 0, 0, 1, 1, 63, 4032});
    tbl.push_back('{129, 0, 1, 0, 0, 0, 0, 0, 0,  0});

    make_frame(0);
    step(0, 0, 1);
    step(0, 0, 1);
    check_reset();

    pulse = 0;
    for (int c = 0; c <= 131; c++) begin
      fv = 1'b0;
      foreach (tbl[k]) if (!tbl[k].is_chk && tbl[k].cyc == c) fv = 1'b1;
      if (fv) begin
        make_frame(pulse);
        pulse++;
      end
      step(fv, 1'b1, 1'b0);
      foreach (tbl[k]) begin
        if (tbl[k].is_chk && tbl[k].cyc == c + 1) begin
          check("t_valid", int'(sample_valid), int'(tbl[k].e_valid));
          check("t_accept", int'(frame_accept), int'(tbl[k].e_accept));
          check("t_overrun", int'(overrun), int'(tbl[k].e_overrun));
          check("t_busy", int'(busy), int'(tbl[k].e_busy));
          if (tbl[k].e_valid) begin
            check("t_last", int'(sample_last), int'(tbl[k].e_last));
            check("t_index", int'(sample_index), int'(tbl[k].e_idx));
            check("t_data", int'(sample_out), int'(tbl[k].e_data));
          end
        end
      end
    end

    // Single ramp frame: samples at cycles 1..64, busy clear at 65.
    make_frame(0);
    step(1, 1, 0);
    check("single_first", int'(sample_out), 0);
    check("single_accept", int'(frame_accept), 1);
    for (int c = 1; c < FL; c++) step(0, 1, 0);
    check("single_last", int'(sample_last), 1);
    check("single_lastdata", int'(sample_out), FL - 1);
    step(0, 1, 0);
    check("single_busy_done", int'(busy), 0);

    // Pending full with a new frame coinciding with the last transfer.
    make_frame(3);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    make_frame(1);
    step(1, 1, 0);
    for (int c = 4; c < FL; c++) step(0, 1, 0);
    make_frame(2);
    step(1, 1, 0);
    check("coinc_accept", int'(frame_accept), 1);
    check("coinc_overrun", int'(overrun), 0);
    check("coinc_data", int'(sample_out), 4095);
    for (int c = 0; c < 2 * FL + 2; c++) step(0, 1, 0);

    // Reset at index 20 with pending full, then a fresh frame.
    make_frame(3);
    step(1, 1, 0);
    step(0, 1, 0);
    make_frame(1);
    step(1, 1, 0);
    for (int c = 3; c <= 20; c++) step(0, 1, 0);
    check("pre_rst_index", int'(sample_index), 20);
    step(0, 1, 1);
    check_reset();
    make_frame(2);
    step(1, 1, 0);
    check("post_rst_index", int'(sample_index), 0);
    check("post_rst_data", int'(sample_out), 12'hA00);
    for (int c = 0; c < FL + 1; c++) step(0, 1, 0);

    // Random traffic: alternating ready first, then random stalls.
    for (int c = 0; c < 3000; c++) begin
      fv = ($urandom_range(0, 24) == 0);
      if (fv) make_frame(3);
      step(fv, (c < 300) ? (c % 2 == 0) : ($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_serializer.md
# frame_serializer

Converts a parallel frame of FRAME_LEN samples back into a one-sample-per-cycle stream with a valid/ready handshake, the inverse of the framing stage. Sits downstream of frame-level processing (windowing, filtering) and feeds serial consumers such as a streaming FFT front end or a DAC playback path. Double-buffered: one frame streams while a second waits, so frame pulses from the framing stage every FRAME_LEN cycles are absorbed without loss.

## Interface
- SAMPLE_W, 12, sample width in bits
- FRAME_LEN, 64, samples per frame; power of two, at least 4
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- frame_in  in  SAMPLE_W x FRAME_LEN  unpacked array [0:FRAME_LEN-1]; sampled only when frame_valid=1
- frame_valid  in  1  single-cycle frame strobe; no backpressure on this side
- frame_accept  out  1  one-cycle pulse, registered; frame captured
- overrun  out  1  one-cycle pulse, registered; frame dropped because both slots were full
- sample_out  out  SAMPLE_W  current sample
- sample_valid  out  1  sample_out is valid
- sample_ready  in  1  consumer accepts; a transfer occurs when sample_valid and sample_ready are both 1
- sample_index  out  log2(FRAME_LEN)  position of sample_out within its frame
- sample_last  out  1  sample_index == FRAME_LEN-1 while sample_valid=1
- busy  out  1  active slot or pending slot holds data

## Operation
- Two storage slots: active (streaming) and pending. Each slot has a valid flag.
- FSM states:
  - IDLE: active slot empty. frame_valid loads the active slot, sets index to 0, and moves to STREAM.
  - STREAM: sample_out = active[index]. On each transfer, index increments. On a transfer with index == FRAME_LEN-1 (last):
    - pending valid: pending moves to active, index goes to 0, FSM stays in STREAM with no bubble.
    - pending empty and no frame_valid: active is cleared and the FSM goes to IDLE.
    - pending empty and frame_valid in the same cycle: the new frame loads directly into active, index goes to 0, FSM stays in STREAM.
- frame_valid while in STREAM:
  - Pending empty: the frame loads pending.
  - Pending full and this cycle is a last transfer: pending moves to active and the new frame loads pending. The frame is accepted.
  - Pending full otherwise: the frame is dropped, overrun pulses, and frame_accept stays 0.
- Accepted frames pulse frame_accept exactly once.
- AXI-style output rules:
  - Once sample_valid=1, sample_out, sample_index and sample_last hold stable until the transfer.
  - sample_valid never drops without a transfer, except on reset.
- Samples pass through unmodified. No arithmetic. Index wraps modulo FRAME_LEN.

## Timing
- Reset values: sample_valid, frame_accept, overrun, busy and sample_last are 0; sample_out and sample_index are 0; FSM is IDLE; both slot valid flags are cleared.
- Reset mid-stream discards both slots. No partial frame resumes.
- Latency: frame_valid at cycle N (FSM in IDLE) gives sample_valid=1 with sample 0 at cycle N+1, and frame_accept=1 at cycle N+1.
- Throughput: with sample_ready held high, one sample per cycle. Back-to-back frames stream with zero idle cycles.
- A single frame with ready held high: samples appear at N+1 .. N+FRAME_LEN, and busy returns to 0 at N+FRAME_LEN+1.
- sample_ready is never required to be high before sample_valid. There is no combinational path from sample_ready to sample_valid or to sample_out.

## Structure
- Shared package audio_pkg holds:
  - SAMPLE_W and FRAME_LEN default constants
  - typedef sample_t (logic [SAMPLE_W-1:0])
  - the FSM state enum ser_state_e {IDLE, STREAM}
- One sub-module, frame_slot: a FRAME_LEN x SAMPLE_W register array with load enable, parallel data in, and an indexed read port.
  - Instantiated twice.
  - The pending-to-active move is a parallel copy through the load input.
- All control (FSM, index counter, slot valid flags, pulse outputs) lives in frame_serializer.

## Test plan
- Single frame, frame_in[k]=k, sample_ready=1, frame_valid at cycle 0:
  - Samples 0..63 appear at cycles 1..64.
  - sample_last=1 only at cycle 64.
  - frame_accept pulses at cycle 1.
  - busy=0 from cycle 65.
- Backpressure, sample_ready toggling 1,0,1,0 plus random stalls:
  - Output sequence is exactly 0..63 with no loss or duplication.
  - Outputs stay stable during stalls.
- Two frames (ramp, then 4095-k), second frame_valid at cycle 10:
  - Second frame goes to pending; two frame_accept pulses.
  - Sample 4095 follows sample 63 on the next cycle with no gap.
- Three frame_valid pulses at cycles 0, 5, 9 with ready=1:
  - Third frame is dropped.
  - overrun=1 at cycle 10 and frame_accept=0 at that cycle.
  - The output stream contains only frames 1 and 2.
- Pending full, frame_valid coincident with the last transfer of the active frame:
  - The frame is accepted and no overrun occurs.
  - All three frames stream contiguously.
- rst asserted at sample_index 20 with pending full:
  - The cycle after rst, all outputs are at reset values.
  - A subsequent frame streams from index 0 correctly.
